reg_alu_seq: RTL
================

REG_ALU_SEQ -- requirements
Module: reg_alu_seq

Interface (parameters: name, default, meaning)
REQ-001 SHALL have parameter DW, 16, datapath width (instruction, immediate, result).
REQ-002 SHALL have parameter AW, 3, register address width (8 registers).

Interface (ports: name, direction, width, meaning)
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr  input  16  instruction word; sampled when instr_valid and instr_ready are both high.
REQ-006 imm  input  DW  immediate for LOAD; sampled together with instr.
REQ-007 instr_valid  input  1  instruction offered.
REQ-008 instr_ready  output  1  sequencer can accept an instruction.
REQ-009 s, wr  output  1 each  reg_alu controls; s=1 writes imm (d_in path), s=0 writes ALU result.
REQ-010 operation  output  2  reg_alu ALU operation.
REQ-011 rd_addr_a, rd_addr_b, wr_addr  output  AW each  reg_alu register addresses.
REQ-012 d_in  output  DW  immediate driven to reg_alu.
REQ-013 d_out_a  input  DW  reg_alu read port A.
REQ-014 cout  input  1  reg_alu carry out.
REQ-015 res_data  output  DW  READ result; res_valid  output  1; res_ready  input  1.
REQ-016 carry_flag  output  1  cout latched by the last ALU instruction.

Function
REQ-017 Instruction fields SHALL be: [15:14] class, [13:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved (ignored).
REQ-018 Class encodings SHALL be: 00 LOAD (rd<-imm), 01 ALU (rd<-ra op rb), 10 READ (res<-ra), 11 NOP.
REQ-019 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-020 IDLE: instr_ready=1; on handshake, register instr and imm and go to EXEC; otherwise stay.
REQ-021 EXEC (exactly one cycle): drive controls from the registered instruction; the next state is RESP for READ and IDLE for every other class.
REQ-022 EXEC LOAD: wr=1, s=1, wr_addr=rd, d_in=imm.
REQ-023 EXEC ALU: wr=1, s=0, operation=op, rd_addr_a=ra, rd_addr_b=rb, wr_addr=rd; carry_flag<=cout at the end of the cycle.
REQ-024 EXEC READ: wr=0, rd_addr_a=ra; res_data<=d_out_a at the end of the cycle.
REQ-025 EXEC NOP: wr=0; no state other than the FSM changes.
REQ-026 RESP: res_valid=1 with res_data stable; on res_ready=1 go to IDLE; otherwise hold.
REQ-027 wr SHALL be 1 only in EXEC for LOAD or ALU, for exactly one cycle per instruction.
REQ-028 Outside EXEC, s, operation, all addresses and d_in SHALL be 0.
REQ-029 instr_ready SHALL be 0 in EXEC and RESP; instr_valid there has no effect.
REQ-030 Throughput SHALL be one LOAD/ALU/NOP per 2 cycles; a register written in EXEC is readable by the next instruction's EXEC.
REQ-031 ALU with rd equal to ra or rb SHALL use pre-write operands (register file writes at the clock edge).
REQ-032 carry_flag SHALL change only on ALU instructions.

Reset
REQ-033 While reset=1, the FSM SHALL be IDLE, and wr, s, operation, addresses, d_in, res_data, res_valid and carry_flag SHALL be 0 immediately, without waiting for a clock edge.
REQ-034 instr_ready SHALL be 0 while reset=1 and 1 in the first cycle after release.
REQ-035 Reset during EXEC SHALL suppress the write; reset during RESP SHALL drop the pending result.

Structure
REQ-036 Class encodings, field bit positions and state encodings SHALL live in a shared header/package (reg_alu_seq_pkg).
REQ-037 Field extraction and class decode SHALL be one combinational sub-module, reg_alu_seq_dec.
REQ-038 The top-level bench SHALL instantiate reg_alu_seq driving reg_alu.

Verification
REQ-039 LOAD rd=3, imm=0x1234, then READ ra=3 -> res_valid with res_data=0x1234; wr pulsed exactly once.
REQ-040 LOAD r1=0x0003, LOAD r2=0x0004, ALU op=00 (add) rd=5 ra=1 rb=2, READ r5 -> 0x0007, carry_flag=0.
REQ-041 LOAD r1=0xFFFF, LOAD r2=0x0001, ALU add rd=1 ra=1 rb=2 -> r1=0x0000, carry_flag=1; a following LOAD leaves carry_flag=1.
REQ-042 READ r0 with res_ready held 0 for 5 cycles -> res_valid and res_data stable, instr_ready=0; res_ready=1 -> IDLE on the next cycle.
REQ-043 reset asserted mid-EXEC of LOAD r4=0xBEEF -> wr falls immediately; READ r4 after release returns the post-reset register value, not 0xBEEF.
REQ-044 NOP with reserved bits 3'b111 -> no wr pulse, no res_valid, instr_ready back to 1 after 2 cycles.

Source files
------------

// File: rtl/reg_alu_seq_pkg.sv
// Shared encodings for the reg_alu instruction sequencer.
// Holds instruction field positions, class codes and FSM state codes.
// No logic; imported by the decoder and the sequencer top.
package reg_alu_seq_pkg;

  localparam int INSTR_W = 16;

  // Instruction field bit positions
  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int RSV_HI = 2;
  localparam int RSV_LO = 0;

  // Instruction classes
  typedef enum logic [1:0] {
    CLS_LOAD = 2'b00,
    CLS_ALU  = 2'b01,
    CLS_READ = 2'b10,
    CLS_NOP  = 2'b11
  } cls_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/reg_alu_seq_dec.sv
// Purpose: split an instruction word into class, op and register fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word directly.
module reg_alu_seq_dec
  import reg_alu_seq_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic [INSTR_W-1:0] instr,
  output cls_e               cls,
  output logic [1:0]         op,
  output logic [AW-1:0]      rd,
  output logic [AW-1:0]      ra,
  output logic [AW-1:0]      rb
);

  // Reserved bits carry no meaning; fold them into a sink so they stay visible.
  logic unused_rsv;
  assign unused_rsv = ^instr[RSV_HI:RSV_LO];

  // Field extraction; register fields are resized to the register address width.
  always_comb begin
    cls = cls_e'(instr[CLS_HI:CLS_LO]);
    op  = instr[OP_HI:OP_LO];
    rd  = AW'(instr[RD_HI:RD_LO]);
    ra  = AW'(instr[RA_HI:RA_LO]);
    rb  = AW'(instr[RB_HI:RB_LO]);
  end

endmodule

// File: rtl/reg_alu_seq.sv
// Purpose: sequence LOAD/ALU/READ/NOP instructions onto a reg_alu register file.
// Latency: 2 cycles per LOAD/ALU/NOP (IDLE+EXEC); READ adds RESP until res_ready.
// Backpressure: instr_ready low outside IDLE; RESP holds res_data until res_ready.
module reg_alu_seq
  import reg_alu_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DW-1:0]      imm,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               s,
  output logic               wr,
  output logic [1:0]         operation,
  output logic [AW-1:0]      rd_addr_a,
  output logic [AW-1:0]      rd_addr_b,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      d_in,
  input  logic [DW-1:0]      d_out_a,
  input  logic               cout,
  output logic [DW-1:0]      res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               carry_flag
);

  state_e               state;
  state_e               state_nxt;
  logic [INSTR_W-1:0]   instr_q;
  logic [DW-1:0]        imm_q;
  logic [DW-1:0]        res_q;
  logic                 carry_q;

  cls_e                 dec_cls;
  logic [1:0]           dec_op;
  logic [AW-1:0]        dec_rd;
  logic [AW-1:0]        dec_ra;
  logic [AW-1:0]        dec_rb;

  logic                 take;
  logic                 in_exec;

  // Accept only in IDLE; in EXEC/RESP instr_valid is ignored.
  assign take    = (state == ST_IDLE) && instr_valid;
  assign in_exec = (state == ST_EXEC);

  // Decode always looks at the registered word, so EXEC controls are glitch-free
  // with respect to whatever the upstream drives on instr meanwhile.
  reg_alu_seq_dec #(
    .AW (AW)
  ) u_dec (
    .instr (instr_q),
    .cls   (dec_cls),
    .op    (dec_op),
    .rd    (dec_rd),
    .ra    (dec_ra),
    .rb    (dec_rb)
  );

  // FSM state register; async reset forces IDLE, which drops all EXEC controls at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: EXEC is always a single cycle, only READ detours through RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = (dec_cls == CLS_READ) ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: every reg_alu control is zero unless EXEC asks for it.
  always_comb begin
    instr_ready = 1'b0;
    wr          = 1'b0;
    s           = 1'b0;
    operation   = 2'b00;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    wr_addr     = '0;
    d_in        = '0;
    res_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = ~reset;
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_LOAD: begin
            wr      = 1'b1;
            s       = 1'b1;
            wr_addr = dec_rd;
            d_in    = imm_q;
          end
          CLS_ALU: begin
            wr        = 1'b1;
            operation = dec_op;
            rd_addr_a = dec_ra;
            rd_addr_b = dec_rb;
            wr_addr   = dec_rd;
          end
          CLS_READ: begin
            rd_addr_a = dec_ra;
          end
          default: begin
          end
        endcase
      end
      ST_RESP: begin
        res_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Instruction/immediate capture on the IDLE handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      imm_q   <= '0;
    end else if (take) begin
      instr_q <= instr;
      imm_q   <= imm;
    end
  end

  // Carry is sampled at the end of an ALU EXEC only; LOAD/READ/NOP leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (in_exec && (dec_cls == CLS_ALU)) begin
      carry_q <= cout;
    end
  end

  // READ result captured at the end of EXEC and held stable through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
    end else if (in_exec && (dec_cls == CLS_READ)) begin
      res_q <= d_out_a;
    end
  end

  assign res_data   = res_q;
  assign carry_flag = carry_q;

endmodule
